// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite layer arbiter and its priority mux.
package sprite_pkg;

  localparam int SPRITE_POS_W  = 16;
  localparam int RGB_W         = 8;
  localparam int N_SPRITES_DEF = 4;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    COMMIT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sprite_priority_mux.sv
// Combinational lowest-index-wins select of a sprite colour from the masked hit
// vector; falls back to the background colour when nothing hits.
module sprite_priority_mux
  import sprite_pkg::*;
#(
  parameter int          N_SPRITES = N_SPRITES_DEF,
  parameter logic [23:0] BG_RGB    = 24'h000000
) (
  input  logic [N_SPRITES-1:0]       hit_mask_i,
  input  logic [RGB_W*N_SPRITES-1:0] red_i,
  input  logic [RGB_W*N_SPRITES-1:0] green_i,
  input  logic [RGB_W*N_SPRITES-1:0] blue_i,
  output rgb_t                       rgb_o
);

  always_comb begin
    // NOTE: the default is assigned before any condition so every path drives
    // rgb_o and no latch is inferred.
    rgb_o = BG_RGB;
    // Scanning from the top index down lets the lowest set index overwrite last.
    for (int k = N_SPRITES - 1; k >= 0; k--) begin
      if (hit_mask_i[k]) begin
        rgb_o = '{r: red_i[RGB_W*k +: RGB_W],
                  g: green_i[RGB_W*k +: RGB_W],
                  b: blue_i[RGB_W*k +: RGB_W]};
      end
    end
  end

endmodule

// File: rtl/sprite_layer_arbiter.sv
// Per-frame sprite position owner with vsync-committed double buffering, plus a
// registered per-pixel priority compositor.
module sprite_layer_arbiter
  import sprite_pkg::*;
#(
  parameter int          N_SPRITES = N_SPRITES_DEF,
  parameter logic [23:0] BG_RGB    = 24'h000000
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_v_sync,
  input  logic                              i_de,
  input  logic [N_SPRITES-1:0]              i_hit,
  input  logic [RGB_W*N_SPRITES-1:0]        i_red,
  input  logic [RGB_W*N_SPRITES-1:0]        i_green,
  input  logic [RGB_W*N_SPRITES-1:0]        i_blue,
  input  logic                              i_wr_valid,
  output logic                              o_wr_ready,
  input  logic [7:0]                        i_wr_idx,
  input  logic [SPRITE_POS_W-1:0]           i_wr_x,
  input  logic [SPRITE_POS_W-1:0]           i_wr_y,
  input  logic                              i_wr_en,
  output logic [SPRITE_POS_W*N_SPRITES-1:0] o_sprite_x,
  output logic [SPRITE_POS_W*N_SPRITES-1:0] o_sprite_y,
  output logic [N_SPRITES-1:0]              o_sprite_en,
  output logic [RGB_W-1:0]                  o_red,
  output logic [RGB_W-1:0]                  o_green,
  output logic [RGB_W-1:0]                  o_blue,
  output logic                              o_valid,
  output logic [15:0]                       o_frame_cnt
);

  arb_state_t state_q, state_d;
  logic       vs_q;
  logic       vs_rise;
  logic       wr_ready;
  logic       wr_fire;
  logic       commit;

  logic [N_SPRITES-1:0][SPRITE_POS_W-1:0] sh_x_q, sh_y_q, act_x_q, act_y_q;
  logic [N_SPRITES-1:0]                   sh_en_q, act_en_q, dirty_q;

  logic [15:0] frame_cnt_q;
  rgb_t        rgb_d, rgb_q;
  logic        valid_q;

  assign vs_rise = i_v_sync & ~vs_q;
  assign wr_fire = i_wr_valid & wr_ready;

  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      ACCEPT: begin
        wr_ready = 1'b1;
        if (vs_rise) state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ACCEPT;
      vs_q        <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= i_v_sync;
      if (commit) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // NOTE: the shadow and active banks are a handful of flops, not a RAM, and
  // must come up at zero, so they sit inside the async reset.
  // Out-of-range indices match no k, which drops the write with no side effect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_x_q   <= '0;
      sh_y_q   <= '0;
      sh_en_q  <= '0;
      dirty_q  <= '0;
      act_x_q  <= '0;
      act_y_q  <= '0;
      act_en_q <= '0;
    end else begin
      if (commit) dirty_q <= '0;
      for (int k = 0; k < N_SPRITES; k++) begin
        if (wr_fire && i_wr_idx == 8'(k)) begin
          sh_x_q[k]  <= i_wr_x;
          sh_y_q[k]  <= i_wr_y;
          sh_en_q[k] <= i_wr_en;
          dirty_q[k] <= 1'b1;
        end
        if (commit && dirty_q[k]) begin
          act_x_q[k]  <= sh_x_q[k];
          act_y_q[k]  <= sh_y_q[k];
          act_en_q[k] <= sh_en_q[k];
        end
      end
    end
  end

  sprite_priority_mux #(
    .N_SPRITES (N_SPRITES),
    .BG_RGB    (BG_RGB)
  ) u_mux (
    .hit_mask_i (i_hit & act_en_q),
    .red_i      (i_red),
    .green_i    (i_green),
    .blue_i     (i_blue),
    .rgb_o      (rgb_d)
  );

  // Loaded every cycle; with i_de low the colour is still well defined.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rgb_q   <= BG_RGB;
      valid_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      valid_q <= i_de;
    end
  end

  assign o_wr_ready  = wr_ready;
  assign o_sprite_x  = act_x_q;
  assign o_sprite_y  = act_y_q;
  assign o_sprite_en = act_en_q;
  assign o_red       = rgb_q.r;
  assign o_green     = rgb_q.g;
  assign o_blue      = rgb_q.b;
  assign o_valid     = valid_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
// Directed bench for sprite_layer_arbiter: a frame-level reference model checked
// every cycle, plus literal expectations at the interesting moments.
module tb_sprite_layer_arbiter;

  localparam int          N  = 4;
  localparam logic [23:0] BG = 24'h203040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_sync = 1'b0;
  logic        de = 1'b0;
  logic [3:0]  hit = '0;
  logic [31:0] red = '0, green = '0, blue = '0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_idx = '0;
  logic [15:0] wr_x = '0, wr_y = '0;
  logic        wr_en = 1'b0;

  logic        o_wr_ready;
  logic [63:0] o_sprite_x, o_sprite_y;
  logic [3:0]  o_sprite_en;
  logic [7:0]  o_red, o_green, o_blue;
  logic        o_valid;
  logic [15:0] o_frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  sprite_layer_arbiter #(.N_SPRITES(N), .BG_RGB(BG)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_v_sync    (v_sync),
    .i_de        (de),
    .i_hit       (hit),
    .i_red       (red),
    .i_green     (green),
    .i_blue      (blue),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (o_wr_ready),
    .i_wr_idx    (wr_idx),
    .i_wr_x      (wr_x),
    .i_wr_y      (wr_y),
    .i_wr_en     (wr_en),
    .o_sprite_x  (o_sprite_x),
    .o_sprite_y  (o_sprite_y),
    .o_sprite_en (o_sprite_en),
    .o_red       (o_red),
    .o_green     (o_green),
    .o_blue      (o_blue),
    .o_valid     (o_valid),
    .o_frame_cnt (o_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        en;
  } pos_t;

  pos_t        m_act[N];
  pos_t        m_pend[int];
  bit          m_commit;
  bit          m_prev_vs;
  int          m_frame;
  logic [23:0] m_rgb;
  logic        m_valid;

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) m_act[k] = '{16'd0, 16'd0, 1'b0};
      m_pend.delete();
      m_commit  = 1'b0;
      m_prev_vs = 1'b0;
      m_frame   = 0;
      m_rgb     = BG;
      m_valid   = 1'b0;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && hit[k] && m_act[k].en) w = k;
      m_rgb   = (w < 0) ? BG : {red[8*w +: 8], green[8*w +: 8], blue[8*w +: 8]};
      m_valid = de;
      // Writes are refused only during the single commit cycle of a frame.
      if (!m_commit && wr_valid && int'(wr_idx) < N)
        m_pend[int'(wr_idx)] = '{wr_x, wr_y, wr_en};
      if (m_commit) begin
        foreach (m_pend[k]) m_act[k] = m_pend[k];
        m_pend.delete();
        m_frame = (m_frame + 1) % 65536;
      end
      m_commit  = v_sync && !m_prev_vs;
      m_prev_vs = v_sync;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rgb", {o_red, o_green, o_blue}, m_rgb);
      check("valid", o_valid, m_valid);
      check("ready", o_wr_ready, !m_commit);
      check("frame", o_frame_cnt, m_frame);
      for (int k = 0; k < N; k++) begin
        check($sformatf("x%0d", k), o_sprite_x[16*k +: 16], m_act[k].x);
        check($sformatf("y%0d", k), o_sprite_y[16*k +: 16], m_act[k].y);
        check($sformatf("en%0d", k), o_sprite_en[k], m_act[k].en);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [7:0] idx, input logic [15:0] x, input logic [15:0] y,
                    input logic en);
    bit acc = 1'b0;
    wr_valid = 1'b1;
    wr_idx   = idx;
    wr_x     = x;
    wr_y     = y;
    wr_en    = en;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = o_wr_ready;
      tick();
    end
    wr_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL wr_accept: write to idx %0d never accepted", idx);
    end
  endtask

  task automatic vsync(input int len);
    v_sync = 1'b1;
    tick(len);
    v_sync = 1'b0;
    tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick();
    cmp_en = 1'b1;

    // Idle after reset: nothing enabled, background for any hit pattern.
    check("rst_en", o_sprite_en, 4'h0);
    check("rst_frame", o_frame_cnt, 16'd0);
    check("rst_rgb", {o_red, o_green, o_blue}, BG);
    red = 32'hAABBCCDD;
    for (int p = 0; p < 4; p++) begin
      hit = 4'(1 << p) | 4'b0001;
      de  = 1'b1;
      tick();
      check("idle_rgb", {o_red, o_green, o_blue}, BG);
    end
    hit = '0;
    de  = 1'b0;

    // Commit latency: position visible exactly two edges after vsync is seen.
    wr(8'd1, 16'd100, 16'd50, 1'b1);
    v_sync = 1'b1;
    tick();
    check("x1_commit_cycle", o_sprite_x[31:16], 16'd0);
    check("ready_commit_cycle", o_wr_ready, 1'b0);
    tick();
    check("x1_after", o_sprite_x[31:16], 16'd100);
    check("y1_after", o_sprite_y[31:16], 16'd50);
    check("frame1", o_frame_cnt, 16'd1);
    v_sync = 1'b0;
    tick(2);

    // Priority: sprite 0 beats sprite 2, sprite 2 wins alone.
    wr(8'd0, 16'd10, 16'd11, 1'b1);
    wr(8'd2, 16'd20, 16'd21, 1'b1);
    vsync(1);
    red = 32'h0011_00FF;
    hit = 4'b0101;
    tick();
    check("prio_0_over_2", o_red, 8'hFF);
    hit = 4'b0100;
    tick();
    check("prio_2_alone", o_red, 8'h11);
    hit = 4'b0000;
    tick();
    check("prio_none", {o_red, o_green, o_blue}, BG);

    // Write held through the commit cycle stalls and lands a frame later.
    v_sync = 1'b1;
    tick();
    wr_valid = 1'b1;
    wr_idx = 8'd3;
    wr_x = 16'd77;
    wr_y = 16'd7;
    wr_en = 1'b1;
    check("stall_ready_low", o_wr_ready, 1'b0);
    tick();
    check("stall_ready_back", o_wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
    v_sync = 1'b0;
    tick(2);
    check("stall_not_yet", o_sprite_x[63:48], 16'd0);
    vsync(1);
    check("stall_committed", o_sprite_x[63:48], 16'd77);

    // Write accepted in the vs_rise cycle joins the immediately following commit.
    wr_valid = 1'b1;
    wr_idx = 8'd1;
    wr_x = 16'd200;
    wr_y = 16'd60;
    wr_en = 1'b1;
    v_sync = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    check("same_cycle_write", o_sprite_x[31:16], 16'd200);
    v_sync = 1'b0;
    tick(2);

    // Out-of-range index dropped; last of two same-index writes wins.
    wr(8'd7, 16'd123, 16'd45, 1'b0);
    wr(8'd0, 16'd5, 16'd1, 1'b1);
    wr(8'd0, 16'd9, 16'd2, 1'b1);
    vsync(1);
    check("last_write_wins", o_sprite_x[15:0], 16'd9);
    check("idx7_no_effect", o_sprite_en, 4'hF);

    // Long vsync pulse commits once.
    check("frame_before_long", o_frame_cnt, 16'd6);
    vsync(5);
    check("frame_after_long", o_frame_cnt, 16'd7);

    // Random pixel traffic over a mixed enable set.
    wr(8'd3, 16'd300, 16'd30, 1'b0);
    vsync(1);
    for (int i = 0; i < 40; i++) begin
      hit   = 4'($urandom);
      red   = $urandom;
      green = $urandom;
      blue  = $urandom;
      de    = 1'($urandom);
      tick();
    end
    hit = '0;
    de  = 1'b0;

    // Reset between a write and vsync discards the pending write.
    wr(8'd2, 16'd33, 16'd3, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_en", o_sprite_en, 4'h0);
    vsync(1);
    check("rst_mid_x", o_sprite_x[31:0], 32'd0);
    check("rst_mid_x_hi", o_sprite_x[63:32], 32'd0);
    check("rst_mid_frame", o_frame_cnt, 16'd1);
    tick(2);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_layer_arbiter.md
# sprite_layer_arbiter

Per-frame controller and per-pixel arbiter for the sprite renderers in the video pipeline. It owns each sprite's on-screen position and enable bit, and double-buffers position updates from the game logic so they commit only at the vertical-sync rising edge. This keeps sprites from tearing mid-frame. Each pixel clock, it also picks the highest-priority enabled sprite that reports a hit and outputs registered RGB, falling back to a background colour.

## Interface
Parameters:
- N_SPRITES, 4: number of sprite layers; index 0 has the highest priority.
- BG_RGB, 24'h000000: background colour {R,G,B}, used when no enabled sprite hits.

Ports:
- i_clk, in, 1: pixel clock, the only clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_v_sync, in, 1: vertical sync, synchronous to i_clk, active-high.
- i_de, in, 1: pixel-valid (data enable) for the current i_x/i_y beat.
- i_hit, in, N_SPRITES: per-sprite o_sprite_hit.
- i_red / i_green / i_blue, in, 8*N_SPRITES each: per-sprite colour, packed with sprite k at bits [8k+7:8k].
- i_wr_valid, in, 1: position-update request.
- o_wr_ready, out, 1: update accepted in cycles where valid and ready are both high.
- i_wr_idx, in, 8: target sprite index.
- i_wr_x / i_wr_y, in, 16 each: new top-left position.
- i_wr_en, in, 1: new enable bit.
- o_sprite_x / o_sprite_y, out, 16*N_SPRITES each: active positions, fed to the sprite renderers.
- o_sprite_en, out, N_SPRITES: active enables.
- o_red / o_green / o_blue, out, 8 each: composited pixel.
- o_valid, out, 1: registered copy of i_de.
- o_frame_cnt, out, 16: count of committed frames.

## Operation
- State machine, two states: ACCEPT and COMMIT. Reset state is ACCEPT.
- ACCEPT:
  - o_wr_ready=1.
  - An accepted write with i_wr_idx < N_SPRITES loads shadow x, y and en for that index and sets its dirty bit.
  - An accepted write with i_wr_idx >= N_SPRITES is dropped, with no state change.
  - Several writes to the same index before a commit: the last one wins.
- Vsync edge detection: r_vs <= i_v_sync; vs_rise = i_v_sync & ~r_vs.
- ACCEPT -> COMMIT on vs_rise.
- COMMIT lasts exactly one cycle:
  - o_wr_ready=0.
  - For every dirty index k, active x/y/en[k] <= shadow[k].
  - All dirty bits are cleared.
  - o_frame_cnt increments, wrapping 0xFFFF -> 0.
  - Next state is ACCEPT unconditionally.
- A write held during COMMIT stalls (requester keeps i_wr_valid high) and is accepted in the following ACCEPT cycle. It commits at the next vsync, not this one.
- A write accepted in the same cycle that vs_rise is seen lands in shadow at that edge and is included in the immediately following COMMIT.
- A vsync pulse longer than one cycle produces exactly one commit. A new commit requires i_v_sync to return low first.
- Pixel arbitration:
  - m = i_hit & o_sprite_en.
  - Winner is the lowest set index in m.
  - Output is the winner's RGB, or BG_RGB if m==0.
- Reset values:
  - State ACCEPT; r_vs=0; dirty=0.
  - Shadow and active x/y all 0; o_sprite_en=0.
  - o_frame_cnt=0; o_valid=0.
  - o_red/o_green/o_blue = BG_RGB.
- Reset asserted mid-operation clears everything above immediately, including pending dirty writes.

## Timing
- Pixel path latency is 1 cycle. Inputs at edge t appear on o_red/o_green/o_blue/o_valid after edge t+1.
- The output register loads unconditionally every cycle; when i_de=0 the content is don't-care but deterministic.
- Commit latency: vs_rise seen in cycle t gives state=COMMIT in cycle t+1, and active positions are visible from cycle t+2.
- o_wr_ready is low for exactly one cycle per frame.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package sprite_pkg:
  - SPRITE_POS_W=16 and RGB_W=8.
  - typedef rgb_t as a struct {r,g,b}.
  - typedef arb_state_t as an enum {ACCEPT, COMMIT}.
  - The N_SPRITES default.
- One sub-module, sprite_priority_mux: combinational lowest-index priority select from the masked hit vector to RGB. It is instantiated once, feeding the output register.

## Test plan
- Reset then idle: o_sprite_en=0, o_frame_cnt=0, output = BG_RGB for any i_hit pattern.
- Write idx1 (x=100, y=50, en=1), then vsync pulse: o_sprite_x[1]=100 exactly 2 cycles after the rising edge; before that it is still 0; o_frame_cnt=1.
- Enable sprites 0 and 2, drive i_hit=4'b0101 with red0=8'hFF, red2=8'h11: o_red=8'hFF one cycle later. With i_hit=4'b0100: o_red=8'h11.
- Hold i_wr_valid through the COMMIT cycle: o_wr_ready=0 for one cycle; the write is accepted next cycle and applied only at the following vsync.
- Write idx=7 with N_SPRITES=4: accepted, no active or shadow change after commit. Two writes to idx0 (x=5 then x=9): x=9 is committed.
- Assert i_rst_n low between a write and vsync: after release, the vsync commit leaves all positions at 0 and o_frame_cnt goes to 1.
